// File: rtl/hmmm_pkg.sv
// Shared HMMM core definitions: instruction/ALU encodings and I/O block defaults.
package hmmm_pkg;

  localparam int IO_DEPTH = 4;
  localparam int IO_WIDTH = 16;

  typedef enum logic [3:0] {
    I_HALT,
    I_READ,
    I_WRITE,
    I_SETN,
    I_ADDN,
    I_COPY,
    I_ADD,
    I_SUB,
    I_MUL,
    I_DIV,
    I_MOD,
    I_JUMPN,
    I_JUMPR,
    I_JEQZN,
    I_JNEZN,
    I_NOP
  } instr_t;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB,
    ALU_MUL,
    ALU_DIV,
    ALU_MOD
  } aluop_t;

  // READ and WRITE are the only instructions that touch the I/O block.
  function automatic logic is_io_instr(input instr_t i);
    return (i == I_READ) || (i == I_WRITE);
  endfunction

endpackage

// File: rtl/hmmm_fifo.sv
// Power-of-two synchronous FIFO with show-ahead head and registered occupancy.
module hmmm_fifo
  import hmmm_pkg::*;
#(
  parameter int DEPTH = IO_DEPTH,
  parameter int WIDTH = IO_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left uninitialised; a cleared count makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/hmmm_io.sv
// HMMM core I/O port: WRITE feeds the host-bound FIFO, READ drains the host-fed FIFO.
module hmmm_io
  import hmmm_pkg::*;
#(
  parameter int DEPTH = IO_DEPTH,
  parameter int WIDTH = IO_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_req,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     stall,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic [$clog2(DEPTH):0]   in_count,
  output logic                     err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             core_wr, core_rd, conflict;
  logic             out_full, in_empty;
  logic             out_push, out_pop, in_push, in_pop;
  logic [WIDTH-1:0] in_head;
  logic             err_q, err_d;

  // Simultaneous READ and WRITE is illegal: neither side of the core acts.
  assign core_wr  = wr_req & ~rd_req;
  assign core_rd  = rd_req & ~wr_req;
  assign conflict = wr_req & rd_req;

  assign out_full = (out_count == CW'(DEPTH));
  assign in_empty = (in_count == '0);

  assign out_push = core_wr & ~out_full;
  assign out_pop  = out_valid & out_ready;
  assign in_push  = in_valid & in_ready;
  assign in_pop   = core_rd & ~in_empty;

  assign out_valid = (out_count != '0);
  assign in_ready  = (in_count != CW'(DEPTH));

  // Stall is forced low while reset is held so the core sees a quiet port.
  assign stall   = reset & ((core_wr & out_full) | (core_rd & in_empty));
  assign rd_data = in_pop ? in_head : '0;

  assign err_d = err_q | conflict;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

  hmmm_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (out_pop),
    .din   (wr_data),
    .dout  (out_data),
    .count (out_count)
  );

  hmmm_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .pop   (in_pop),
    .din   (in_data),
    .dout  (in_head),
    .count (in_count)
  );

endmodule

// File: tb/tb_hmmm_io.sv
// Scoreboard bench for hmmm_io: queue-based reference model, directed plus random traffic.
module tb_hmmm_io;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_req, rd_req, out_ready, in_valid;
  logic [WIDTH-1:0] wr_data, in_data, rd_data, out_data;
  logic             stall, out_valid, in_ready, err;
  logic [CW-1:0]    out_count, in_count;

  int n_vec  = 0;
  int n_miss = 0;

  logic [WIDTH-1:0] m_out[$];
  logic [WIDTH-1:0] m_in[$];
  bit               m_err;
  logic [WIDTH-1:0] exp_out[$];
  logic [WIDTH-1:0] exp_rd[$];

  always #5 clk = ~clk;

  hmmm_io #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .stall     (stall),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_count (out_count),
    .in_count  (in_count),
    .err       (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every transfer the DUT presents must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL out_pop: got word %0h, expected no transfer", out_data);
        end else chk("out_data", out_data, exp_out.pop_front());
      end
      if (rd_req && !wr_req && !stall) begin
        if (exp_rd.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL core_read: got word %0h, expected no transfer", rd_data);
        end else chk("rd_data", rd_data, exp_rd.pop_front());
      end
    end
  end

  // One clock of stimulus; the model predicts outputs from FIFO contents, then advances.
  task automatic cyc(input logic w, input logic [WIDTH-1:0] wd, input logic r,
                     input logic ordy, input logic iv, input logic [WIDTH-1:0] id);
    bit core_push, host_pop, host_push, core_pop, e_stall;
    @(posedge clk); #1;
    wr_req = w; wr_data = wd; rd_req = r;
    out_ready = ordy; in_valid = iv; in_data = id;
    core_push = w && !r && (m_out.size() < DEPTH);
    host_pop  = (m_out.size() != 0) && ordy;
    host_push = iv && (m_in.size() < DEPTH);
    core_pop  = r && !w && (m_in.size() != 0);
    e_stall   = (w && !r && m_out.size() == DEPTH) || (r && !w && m_in.size() == 0);
    if (host_pop) exp_out.push_back(m_out[0]);
    if (core_pop) exp_rd.push_back(m_in[0]);
    @(negedge clk);
    chk("stall", 32'(stall), 32'(e_stall));
    chk("out_valid", 32'(out_valid), 32'(m_out.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(m_in.size() < DEPTH));
    chk("out_count", 32'(out_count), 32'(m_out.size()));
    chk("in_count", 32'(in_count), 32'(m_in.size()));
    chk("err", 32'(err), 32'(m_err));
    if (!core_pop) chk("rd_data_idle", 32'(rd_data), 32'd0);
    if (host_pop)  void'(m_out.pop_front());
    if (core_push) m_out.push_back(wd);
    if (core_pop)  void'(m_in.pop_front());
    if (host_push) m_in.push_back(id);
    if (w && r)    m_err = 1'b1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; wr_req = 1'b0; wr_data = '0; rd_req = 1'b1;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    m_err = 1'b0;
    #3;
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_count", 32'(in_count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #9;
    rd_req = 1'b0;
    reset  = 1'b1;

    // Single WRITE, visible next cycle, popped by the ready host.
    cyc(1'b1, 16'h0005, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

    // Fill to DEPTH, stall on the fifth, release with one host pop.
    for (int i = 1; i <= 4; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 16'd5, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

    // READ on empty input FIFO stalls; a same-cycle host push does not bypass.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 16'h002A);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    idle();

    // Interleaved host pushes and READs across pointer wrap.
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'd2);
    for (int i = 3; i <= 10; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, WIDTH'(i));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    idle();

    // Queue words, then pulse reset between edges.
    cyc(1'b1, 16'd7, 1'b0, 1'b0, 1'b1, 16'h0A);
    cyc(1'b1, 16'd8, 1'b0, 1'b0, 1'b1, 16'h0B);
    cyc(1'b1, 16'd9, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("pulse_out_count", 32'(out_count), 32'd0);
    chk("pulse_in_count", 32'(in_count), 32'd0);
    chk("pulse_out_valid", 32'(out_valid), 32'd0);
    chk("pulse_in_ready", 32'(in_ready), 32'd1);
    chk("pulse_stall", 32'(stall), 32'd0);
    chk("pulse_sb_empty", 32'(exp_out.size() + exp_rd.size()), 32'd0);
    m_out.delete(); m_in.delete(); m_err = 1'b0;
    #1 reset = 1'b1;
    idle();

    // Random traffic; WRITE and READ are never issued together here.
    for (int i = 0; i < 400; i++) begin
      logic w, r;
      w = ($urandom % 3) == 0;
      r = !w && (($urandom % 3) == 0);
      cyc(w, WIDTH'($urandom), r, 1'($urandom), 1'($urandom), WIDTH'($urandom));
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);

    // Illegal READ+WRITE: no core action, err sticks.
    cyc(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 16'h0022);
    cyc(1'b1, 16'h0012, 1'b0, 1'b0, 1'b1, 16'h0023);
    cyc(1'b1, 16'h0033, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) idle();
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
    idle();

    chk("sb_out_drained", 32'(exp_out.size()), 32'd0);
    chk("sb_rd_drained", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
